// File: rtl/pal_timing_events.sv
// rtl/pal_timing_events.sv - PAL video-timing event generator with continuity-checked lock FSM
module pal_timing_events #(
  parameter int X_WIDTH           = 10,
  parameter int Y_WIDTH           = 10,
  parameter int NUM_EVENTS        = 4,
  parameter int FRAME_COUNT_WIDTH = 16,
  parameter int LOCK_FRAMES       = 2,
  parameter int GATE_EVENTS       = 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [X_WIDTH-1:0]              pixel_x,
  input  logic [Y_WIDTH-1:0]              pixel_y,
  input  logic                            pixel_ce,
  input  logic [NUM_EVENTS-1:0]           event_en,
  input  logic [NUM_EVENTS*X_WIDTH-1:0]   event_x,
  input  logic [NUM_EVENTS*Y_WIDTH-1:0]   event_y,
  output logic                            frame_start,
  output logic                            line_start,
  output logic [NUM_EVENTS-1:0]           event_pulse,
  output logic [FRAME_COUNT_WIDTH-1:0]    frame_count,
  output logic                            locked,
  output logic                            sync_error
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  localparam logic [3:0] LP_LOCK_FRAMES = 4'(LOCK_FRAMES);

  state_t               r_state;
  logic [3:0]           r_acq_cnt;
  logic [X_WIDTH-1:0]   r_prev_x;
  logic [Y_WIDTH-1:0]   r_prev_y;
  logic                 r_prev_valid;

  logic                  w_x_zero;
  logic                  w_origin;
  logic [X_WIDTH:0]      w_x_inc;
  logic [Y_WIDTH-1:0]    w_y_inc;
  logic                  w_step_x;
  logic                  w_step_line;
  logic                  w_err;
  logic                  w_clear;
  logic                  w_gate;
  logic [3:0]            w_acq_next;
  logic [NUM_EVENTS-1:0] w_match;

  assign w_x_zero    = (pixel_x == '0);
  assign w_origin    = w_x_zero && (pixel_y == '0);
  // x increment is one bit wider so that an all-ones column can never continue on the same line
  assign w_x_inc     = {1'b0, r_prev_x} + {{X_WIDTH{1'b0}}, 1'b1};
  assign w_y_inc     = r_prev_y + {{(Y_WIDTH-1){1'b0}}, 1'b1};
  assign w_step_x    = ({1'b0, pixel_x} == w_x_inc) && (pixel_y == r_prev_y);
  assign w_step_line = w_x_zero && (pixel_y == w_y_inc);
  assign w_err       = pixel_ce && r_prev_valid && !(w_step_x || w_step_line || w_origin);
  assign w_clear     = w_err && (r_state != ST_UNLOCKED);
  assign w_gate      = (GATE_EVENTS == 0) || (r_state == ST_LOCKED);
  assign w_acq_next  = r_acq_cnt + 4'd1;

  always_comb begin
    w_match = '0;
    for (int n = 0; n < NUM_EVENTS; n++) begin
      w_match[n] = event_en[n]
                && (pixel_x == event_x[n*X_WIDTH +: X_WIDTH])
                && (pixel_y == event_y[n*Y_WIDTH +: Y_WIDTH]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_start  <= 1'b0;
      line_start   <= 1'b0;
      event_pulse  <= '0;
      sync_error   <= 1'b0;
      r_prev_x     <= '0;
      r_prev_y     <= '0;
      r_prev_valid <= 1'b0;
    end else begin
      frame_start <= pixel_ce && w_origin;
      line_start  <= pixel_ce && w_x_zero;
      event_pulse <= (pixel_ce && w_gate) ? w_match : '0;
      sync_error  <= w_err;
      if (pixel_ce) begin
        r_prev_x     <= pixel_x;
        r_prev_y     <= pixel_y;
        r_prev_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_UNLOCKED;
      r_acq_cnt   <= '0;
      locked      <= 1'b0;
      frame_count <= '0;
    end else if (pixel_ce) begin
      if (w_clear) begin
        frame_count <= '0;
      end else if (w_origin) begin
        frame_count <= frame_count + {{(FRAME_COUNT_WIDTH-1){1'b0}}, 1'b1};
      end
      case (r_state)
        ST_UNLOCKED: begin
          if (w_origin) begin
            r_state   <= ST_ACQUIRE;
            r_acq_cnt <= '0;
          end
        end
        ST_ACQUIRE: begin
          if (w_err) begin
            r_state   <= ST_UNLOCKED;
            r_acq_cnt <= '0;
          end else if (w_origin) begin
            if (w_acq_next == LP_LOCK_FRAMES) begin
              r_state   <= ST_LOCKED;
              r_acq_cnt <= '0;
              locked    <= 1'b1;
            end else begin
              r_acq_cnt <= w_acq_next;
            end
          end
        end
        ST_LOCKED: begin
          if (w_err) begin
            r_state <= ST_UNLOCKED;
            locked  <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_UNLOCKED;
          r_acq_cnt <= '0;
          locked    <= 1'b0;
        end
      endcase
    end
  end

endmodule
